// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 interrupt path: register map, controller state codes, trap causes.
// Latency: n/a (constants and one combinational helper).
// Backpressure: n/a.
package msrv32_pkg;

  // Register word addresses on the controller's load/store port
  localparam logic [3:0] IRQ_ENABLE      = 4'd0;
  localparam logic [3:0] IRQ_MODE        = 4'd1;
  localparam logic [3:0] IRQ_PENDING     = 4'd2;
  localparam logic [3:0] IRQ_CLAIM       = 4'd3;
  localparam logic [3:0] IRQ_MSIP        = 4'd4;
  localparam logic [3:0] IRQ_MTIMECMP_LO = 4'd5;
  localparam logic [3:0] IRQ_MTIMECMP_HI = 4'd6;
  localparam logic [3:0] IRQ_MTIME_LO    = 4'd7;
  localparam logic [3:0] IRQ_MTIME_HI    = 4'd8;

  typedef logic [1:0] irq_state_t;

  // Claim/complete state encoding
  localparam irq_state_t IDLE       = 2'd0;
  localparam irq_state_t REQ        = 2'd1;
  localparam irq_state_t IN_SERVICE = 2'd2;

  localparam logic [4:0] NO_CLAIM = 5'h1F;

  // mcause codes used by machine control
  localparam logic [3:0] CAUSE_M_EXT_IRQ   = 4'd11;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ = 4'd7;
  localparam logic [3:0] CAUSE_M_SW_IRQ    = 4'd3;

  // Fixed priority: the lowest set index wins; NO_CLAIM when nothing is set.
  function automatic logic [4:0] irq_winner(input logic [15:0] act);
    logic [4:0] w;
    w = NO_CLAIM;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) w = 5'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/msrv32_irq_controller_if.sv
// Register port between the load/store path and the interrupt controller.
// Latency: writes take effect on the next clk_in edge; reads are combinational.
// Backpressure: none; the port is always ready.
// Ports: wr_en_in/wr_addr_in/wr_data_in write strobe, address, data;
//        rd_addr_in read address; rd_data_out read data.
interface msrv32_irq_controller_if;
  logic        wr_en_in;
  logic [3:0]  wr_addr_in;
  logic [31:0] wr_data_in;
  logic [3:0]  rd_addr_in;
  logic [31:0] rd_data_out;

  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, rd_addr_in,
    input  rd_data_out
  );

  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, rd_addr_in,
    output rd_data_out
  );
endinterface

// File: rtl/msrv32_mtimer.sv
// Machine timer: prescaler, 64-bit mtime, MTIMECMP and the registered timer-interrupt compare.
// Latency: MTIMECMP write visible next cycle; t_irq_out one cycle behind the compare.
// Backpressure: none; writes are always accepted.
// Ports: clk_in, rst_n_in; wr_en_in/wr_addr_in/wr_data_in register writes;
//        mtime_out, mtimecmp_out current values; t_irq_out timer request.
module msrv32_mtimer
  import msrv32_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        wr_en_in,
  input  logic [3:0]  wr_addr_in,
  input  logic [31:0] wr_data_in,
  output logic [63:0] mtime_out,
  output logic [63:0] mtimecmp_out,
  output logic        t_irq_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q;
  logic [63:0]   mtime_q;
  logic [63:0]   mtimecmp_q;
  logic          presc_wrap;

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
      // Natural 64-bit overflow gives the wrap to zero
      if (presc_wrap) mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mtimecmp_q <= '1;
    end else if (wr_en_in) begin
      if (wr_addr_in == IRQ_MTIMECMP_LO) mtimecmp_q[31:0]  <= wr_data_in;
      if (wr_addr_in == IRQ_MTIMECMP_HI) mtimecmp_q[63:32] <= wr_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) t_irq_out <= 1'b0;
    else           t_irq_out <= (mtime_q >= mtimecmp_q);
  end

  assign mtime_out    = mtime_q;
  assign mtimecmp_out = mtimecmp_q;

endmodule

// File: rtl/msrv32_irq_controller.sv
// Machine-level interrupt controller: sync/prioritise external lines, claim/complete, timer and MSIP.
// Latency: raw rise -> PENDING in 3 cycles, e_irq_out 1 cycle later; reads combinational.
// Backpressure: none; e_irq_out held until ack or until the request is withdrawn.
// Ports: clk_in, rst_n_in; ext_irq_in raw lines; irq_ack_in/irq_complete_in trap handshake;
//        reg_bus register port; e/t/s_irq_out requests to machine control; claim_id_out.
module msrv32_irq_controller
  import msrv32_pkg::*;
#(
  parameter int NUM_EXT  = 4,
  parameter int PRESCALE = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_EXT-1:0]   ext_irq_in,
  input  logic                 irq_ack_in,
  input  logic                 irq_complete_in,
  msrv32_irq_controller_if.slave reg_bus,
  output logic                 e_irq_out,
  output logic                 t_irq_out,
  output logic                 s_irq_out,
  output logic [4:0]           claim_id_out
);

  logic [NUM_EXT-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_EXT-1:0] edge_pend_q, enable_q, mode_q;
  logic               msip_q;
  irq_state_t         state_q;

  logic [NUM_EXT-1:0] rise, pending, active, w1c_clr, claim_clr, winner_onehot;
  logic [4:0]         winner;
  logic               any_active, claim_wr, complete, take_claim;
  logic [63:0]        mtime, mtimecmp;

  // Two-flop synchroniser per line; prev_q gives the rising-edge reference
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ext_irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise       = sync2_q & ~prev_q;
  // Level sources mirror the synchronised line; edge sources use the sticky bit
  assign pending    = (edge_pend_q & mode_q) | (sync2_q & ~mode_q);
  assign active     = pending & enable_q;
  assign any_active = |active;
  assign winner     = irq_winner(16'(active));
  assign winner_onehot = NUM_EXT'(1) << winner;

  assign claim_wr   = reg_bus.wr_en_in && (reg_bus.wr_addr_in == IRQ_CLAIM);
  assign complete   = irq_complete_in || claim_wr;
  assign take_claim = (state_q == REQ) && irq_ack_in && any_active;
  assign claim_clr  = take_claim ? winner_onehot : '0;
  assign w1c_clr    = (reg_bus.wr_en_in && (reg_bus.wr_addr_in == IRQ_PENDING))
                      ? reg_bus.wr_data_in[NUM_EXT-1:0] : '0;

  // Set is ORed in after the clear so a same-cycle edge survives a W1C or claim
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) edge_pend_q <= '0;
    else           edge_pend_q <= ((edge_pend_q & ~(w1c_clr | claim_clr)) | rise) & mode_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      enable_q <= '0;
      mode_q   <= '0;
      msip_q   <= 1'b0;
    end else if (reg_bus.wr_en_in) begin
      if (reg_bus.wr_addr_in == IRQ_ENABLE) enable_q <= reg_bus.wr_data_in[NUM_EXT-1:0];
      if (reg_bus.wr_addr_in == IRQ_MODE)   mode_q   <= reg_bus.wr_data_in[NUM_EXT-1:0];
      if (reg_bus.wr_addr_in == IRQ_MSIP)   msip_q   <= reg_bus.wr_data_in[0];
    end
  end

  assign s_irq_out = msip_q;

  // Claim/complete handshake; no nesting while a claim is in service
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      e_irq_out    <= 1'b0;
      claim_id_out <= NO_CLAIM;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_active) begin
            state_q   <= REQ;
            e_irq_out <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack_in) begin
            // Ack with nothing active still enters service, with a spurious ID
            state_q      <= IN_SERVICE;
            e_irq_out    <= 1'b0;
            claim_id_out <= any_active ? winner : NO_CLAIM;
          end else if (!any_active) begin
            state_q   <= IDLE;
            e_irq_out <= 1'b0;
          end
        end
        IN_SERVICE: begin
          if (complete) begin
            state_q      <= IDLE;
            claim_id_out <= NO_CLAIM;
          end
        end
        default: begin
          state_q      <= IDLE;
          e_irq_out    <= 1'b0;
          claim_id_out <= NO_CLAIM;
        end
      endcase
    end
  end

  msrv32_mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .wr_en_in     (reg_bus.wr_en_in),
    .wr_addr_in   (reg_bus.wr_addr_in),
    .wr_data_in   (reg_bus.wr_data_in),
    .mtime_out    (mtime),
    .mtimecmp_out (mtimecmp),
    .t_irq_out    (t_irq_out)
  );

  always_comb begin
    reg_bus.rd_data_out = 32'd0;
    case (reg_bus.rd_addr_in)
      IRQ_ENABLE:      reg_bus.rd_data_out = 32'(enable_q);
      IRQ_MODE:        reg_bus.rd_data_out = 32'(mode_q);
      IRQ_PENDING:     reg_bus.rd_data_out = 32'(pending);
      IRQ_CLAIM:       reg_bus.rd_data_out = 32'(claim_id_out);
      IRQ_MSIP:        reg_bus.rd_data_out = 32'(msip_q);
      IRQ_MTIMECMP_LO: reg_bus.rd_data_out = mtimecmp[31:0];
      IRQ_MTIMECMP_HI: reg_bus.rd_data_out = mtimecmp[63:32];
      IRQ_MTIME_LO:    reg_bus.rd_data_out = mtime[31:0];
      IRQ_MTIME_HI:    reg_bus.rd_data_out = mtime[63:32];
      default:         reg_bus.rd_data_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_msrv32_irq_controller.sv
// Directed bench for msrv32_irq_controller with an expected-value queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_msrv32_irq_controller;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [3:0] ext_irq_in;
  logic       irq_ack_in, irq_complete_in;
  logic       e_irq_out, t_irq_out, s_irq_out;
  logic [4:0] claim_id_out;

  always #5 clk_in = ~clk_in;

  msrv32_irq_controller_if bus ();

  msrv32_irq_controller #(.NUM_EXT(4), .PRESCALE(1)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .ext_irq_in      (ext_irq_in),
    .irq_ack_in      (irq_ack_in),
    .irq_complete_in (irq_complete_in),
    .reg_bus         (bus),
    .e_irq_out       (e_irq_out),
    .t_irq_out       (t_irq_out),
    .s_irq_out       (s_irq_out),
    .claim_id_out    (claim_id_out)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=0x%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus.wr_en_in   = 1'b1;
    bus.wr_addr_in = a;
    bus.wr_data_in = d;
    @(negedge clk_in);
    bus.wr_en_in   = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus.rd_addr_in = a;
    #1;
    d = bus.rd_data_out;
  endtask

  task automatic pulse_ack();
    irq_ack_in = 1'b1;
    @(negedge clk_in);
    irq_ack_in = 1'b0;
  endtask

  task automatic pulse_complete();
    irq_complete_in = 1'b1;
    @(negedge clk_in);
    irq_complete_in = 1'b0;
  endtask

  // Bounded wait for a request; timing out shows up as a failed comparison
  task automatic wait_eirq(input string tag);
    int n;
    n = 0;
    expect_val(tag, 32'd1);
    while (e_irq_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    observe(32'(e_irq_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] prev_mtime;

    rst_n_in        = 1'b0;
    ext_irq_in      = '0;
    irq_ack_in      = 1'b0;
    irq_complete_in = 1'b0;
    bus.wr_en_in    = 1'b0;
    bus.wr_addr_in  = '0;
    bus.wr_data_in  = '0;
    bus.rd_addr_in  = '0;
    tick(3);
    rst_n_in = 1'b1;

    // Reset state
    expect_val("rst_claim", 32'h1F);  observe(32'(claim_id_out));
    expect_val("rst_eirq", 32'd0);    observe(32'(e_irq_out));
    expect_val("rst_sirq", 32'd0);    observe(32'(s_irq_out));
    expect_val("rst_enable", 32'd0);  rd_reg(4'd0, d); observe(d);
    expect_val("rst_cmp_lo", 32'hFFFF_FFFF); rd_reg(4'd5, d); observe(d);
    tick();

    // 1: edge source 0, claim then complete
    wr_reg(4'd0, 32'h1);
    wr_reg(4'd1, 32'h1);
    expect_val("t1_pending_c3", 32'h1);
    expect_val("t1_eirq_c3", 32'd0);
    expect_val("t1_eirq_c4", 32'd1);
    ext_irq_in = 4'b0001;
    tick();
    ext_irq_in = 4'b0000;
    tick(2);
    rd_reg(4'd2, d); observe(d);
    observe(32'(e_irq_out));
    tick();
    observe(32'(e_irq_out));
    expect_val("t1_claim", 32'd0);
    expect_val("t1_pending_cleared", 32'd0);
    expect_val("t1_eirq_in_service", 32'd0);
    pulse_ack();
    observe(32'(claim_id_out));
    rd_reg(4'd2, d); observe(d);
    observe(32'(e_irq_out));
    expect_val("t1_complete", 32'h1F);
    pulse_complete();
    observe(32'(claim_id_out));

    // 2: level sources 3 and 1, priority and re-request
    wr_reg(4'd1, 32'h0);
    wr_reg(4'd0, 32'hF);
    ext_irq_in = 4'b1010;
    wait_eirq("t2_req_a");
    expect_val("t2_claim_a", 32'd1);
    pulse_ack();
    observe(32'(claim_id_out));
    expect_val("t2_claim_wr_complete", 32'h1F);
    wr_reg(4'd3, 32'h0);
    observe(32'(claim_id_out));
    expect_val("t2_rereq_c1", 32'd0);
    observe(32'(e_irq_out));
    tick();
    expect_val("t2_rereq_c2", 32'd1);
    observe(32'(e_irq_out));
    expect_val("t2_claim_b", 32'd1);
    pulse_ack();
    observe(32'(claim_id_out));
    ext_irq_in = 4'b1000;
    tick(3);
    pulse_complete();
    wait_eirq("t2_req_c");
    expect_val("t2_claim_c", 32'd3);
    pulse_ack();
    observe(32'(claim_id_out));
    ext_irq_in = 4'b0000;
    pulse_complete();
    tick(4);
    expect_val("t2_quiet", 32'd0);
    observe(32'(e_irq_out));

    // 3: edge on source 2 coincides with W1C of bit 2
    wr_reg(4'd1, 32'h4);
    ext_irq_in = 4'b0100;
    tick(2);
    wr_reg(4'd2, 32'h4);
    expect_val("t3_set_wins", 32'h4);
    rd_reg(4'd2, d); observe(d);
    ext_irq_in = 4'b0000;
    wr_reg(4'd2, 32'h4);
    expect_val("t3_w1c_clears", 32'h0);
    rd_reg(4'd2, d); observe(d);
    tick(2);
    expect_val("t3_eirq_withdrawn", 32'd0);
    observe(32'(e_irq_out));

    // 4: level source 0, disabled before ack -> spurious claim
    wr_reg(4'd1, 32'h0);
    ext_irq_in = 4'b0001;
    wait_eirq("t4_req");
    wr_reg(4'd2, 32'hF);
    expect_val("t4_level_no_w1c", 32'h1);
    rd_reg(4'd2, d); observe(d);
    tick();
    wr_reg(4'd0, 32'h0);
    expect_val("t4_eirq_still_up", 32'd1);
    observe(32'(e_irq_out));
    expect_val("t4_eirq_dropped", 32'd0);
    expect_val("t4_spurious_claim", 32'h1F);
    pulse_ack();
    observe(32'(e_irq_out));
    observe(32'(claim_id_out));
    wr_reg(4'd0, 32'h1);
    tick(3);
    expect_val("t4_no_nesting", 32'd0);
    observe(32'(e_irq_out));
    pulse_complete();
    wait_eirq("t4_rereq");
    expect_val("t4_claim", 32'd0);
    pulse_ack();
    observe(32'(claim_id_out));
    ext_irq_in = 4'b0000;
    pulse_complete();
    tick(4);

    // 5: timer compare against MTIMECMP = 10 from a fresh mtime
    rst_n_in = 1'b0;
    tick(2);
    rst_n_in = 1'b1;
    wr_reg(4'd6, 32'h0);
    wr_reg(4'd5, 32'd10);
    rd_reg(4'd7, prev_mtime);
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_val($sformatf("t5_tirq_mtime%0d", prev_mtime), 32'(prev_mtime >= 32'd10));
      observe(32'(t_irq_out));
      rd_reg(4'd7, prev_mtime);
    end
    wr_reg(4'd5, 32'hFFFF_FFFF);
    expect_val("t5_tirq_old_cmp", 32'd1);
    observe(32'(t_irq_out));
    tick();
    expect_val("t5_tirq_new_cmp", 32'd0);
    observe(32'(t_irq_out));
    expect_val("t5_mtime_hi", 32'd0);
    rd_reg(4'd8, d); observe(d);
    expect_val("t5_unmapped", 32'd0);
    rd_reg(4'd9, d); observe(d);
    tick();

    // 6: asynchronous reset while a claim is in service, MSIP set
    wr_reg(4'd4, 32'h1);
    expect_val("t6_sirq", 32'd1);
    observe(32'(s_irq_out));
    wr_reg(4'd0, 32'h1);
    ext_irq_in = 4'b0001;
    wait_eirq("t6_req");
    expect_val("t6_claim", 32'd0);
    pulse_ack();
    observe(32'(claim_id_out));
    expect_val("t6_rst_claim", 32'h1F);
    expect_val("t6_rst_eirq", 32'd0);
    expect_val("t6_rst_sirq", 32'd0);
    expect_val("t6_rst_tirq", 32'd0);
    expect_val("t6_rst_enable", 32'd0);
    #2;
    rst_n_in = 1'b0;
    #1;
    observe(32'(claim_id_out));
    observe(32'(e_irq_out));
    observe(32'(s_irq_out));
    observe(32'(t_irq_out));
    rd_reg(4'd0, d); observe(d);
    ext_irq_in = 4'b0000;
    tick(2);
    rst_n_in = 1'b1;
    tick(2);

    while (exp_q.size() != 0) begin
      failures++;
      $error("FAIL %s observed=none expected=0x%0h", tag_q.pop_front(), exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_irq_controller.md
Name: msrv32_irq_controller

Overview:
Machine-level interrupt controller for the msrv32 core. It synchronises and prioritises the external interrupt lines and runs a claim/complete handshake with trap entry. It also holds the machine timer (mtime/mtimecmp) and the software-interrupt bit. Outputs e_irq_out, t_irq_out and s_irq_out drive the e_irq_in, t_irq_in and s_irq_in inputs of msrv32_machine_control; a simple register port connects it to the load/store path.

Parameters:
NUM_EXT, 4, number of external interrupt sources (1..16); index 0 is highest priority
PRESCALE, 1, clk_in cycles per mtime increment (>=1)

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  asynchronous active-low reset
ext_irq_in  input  NUM_EXT  raw asynchronous external interrupt lines
irq_ack_in  input  1  one-cycle pulse: machine control took an external-interrupt trap
irq_complete_in  input  1  one-cycle pulse: handler finished (alternative to a CLAIM write)
wr_en_in  input  1  register write strobe
wr_addr_in  input  4  register word address
wr_data_in  input  32  write data
rd_addr_in  input  4  read address
rd_data_out  output  32  combinational read data
e_irq_out  output  1  external interrupt request
t_irq_out  output  1  timer interrupt request
s_irq_out  output  1  software interrupt request
claim_id_out  output  5  ID of the source in service; 0x1F when none

Behaviour:
- Register map (word addresses):
  - 0 ENABLE[NUM_EXT-1:0]: read/write.
  - 1 MODE: 1 = edge, 0 = level; read/write.
  - 2 PENDING: read; write-1-to-clear, edge bits only.
  - 3 CLAIM: read returns claim_id_out; any write = complete.
  - 4 MSIP[0].
  - 5/6 MTIMECMP lo/hi.
  - 7/8 MTIME lo/hi: read-only.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values:
  - ENABLE = 0, MODE = 0, PENDING = 0, MSIP = 0.
  - MTIMECMP = all ones; MTIME = 0; prescaler = 0.
  - State = IDLE.
  - e_irq_out, t_irq_out and s_irq_out = 0; claim_id_out = 0x1F.
- Synchroniser: 2 flip-flops per ext_irq_in line; each bit is synchronised independently. A rising edge is detected from the synchronised value against its previous value, so a raw-input rise sets the pending bit 3 cycles later.
- Pending:
  - Edge source: the bit is set on a rising edge and cleared by claim or by a W1C write. Set wins over a same-cycle clear.
  - Level source: the bit equals the synchronised level and cannot be cleared.
- Active vector = PENDING & ENABLE. Winner = lowest set index; combinational, no fairness.
- State machine:
  - IDLE: if the active vector is non-zero, go to REQ.
  - REQ: e_irq_out = 1 (registered, asserted the cycle REQ is entered). If the active vector becomes 0 (source withdrawn or disabled), go back to IDLE and drop e_irq_out. On irq_ack_in, latch the winner into claim_id_out, clear its pending bit if it is an edge source, and go to IN_SERVICE.
  - IN_SERVICE: e_irq_out = 0, with no nesting. On irq_complete_in or a CLAIM write, set claim_id_out = 0x1F and go to IDLE. A pending source re-requests 2 cycles after complete.
  - irq_ack_in in IDLE or IN_SERVICE is ignored.
  - irq_ack_in in REQ while the active vector is 0 in the same cycle: claim_id_out = 0x1F and go to IN_SERVICE (spurious claim).
- Timer:
  - The prescaler counts 0..PRESCALE-1; mtime (64-bit) increments when the prescaler wraps. mtime wraps at 2^64-1 to 0.
  - t_irq_out is registered: t_irq_out <= (mtime >= MTIMECMP), unsigned, one cycle behind the compare.
  - A MTIMECMP half-write takes effect on the next cycle.
- s_irq_out = MSIP[0], registered.
- Simultaneous register write and hardware event on the same bit: the hardware set wins for PENDING; for all other registers the software write wins.
- When rst_n_in is asserted mid-operation, all state returns to its reset value immediately, including any in-service claim.

Decomposition:
- Shared package msrv32_pkg holds the register-address constants (IRQ_ENABLE .. IRQ_MTIME_HI), the state encoding (IDLE = 2'd0, REQ = 2'd1, IN_SERVICE = 2'd2), NO_CLAIM = 5'h1F, and the cause constants 11/7/3 already used by machine control.
- One sub-module: msrv32_mtimer, containing the prescaler, mtime, MTIMECMP and the t_irq compare. Its inputs are the write port and its outputs are mtime plus t_irq.

Test Plan:
1. Reset, then ENABLE = 0x1 and MODE = 0x1, then pulse ext_irq_in[0] for 1 cycle -> PENDING = 0x1 after 3 cycles and e_irq_out = 1 after 4 cycles; irq_ack_in -> claim_id_out = 0, PENDING = 0; complete -> claim_id_out = 0x1F.
2. ENABLE = 0xF with level sources 3 and 1 held high -> claim_id_out = 1. After complete, e_irq_out re-asserts and the next claim is again 1; drop line 1 -> the next claim = 3.
3. Edge on source 2 in the same cycle as a W1C write of bit 2 -> PENDING[2] stays 1.
4. Level source 0 rises, then ENABLE = 0 before ack -> e_irq_out falls the next cycle; irq_ack_in then gives a spurious claim, claim_id_out = 0x1F.
5. PRESCALE = 1, MTIMECMP = 10 -> t_irq_out = 1 in the cycle after mtime = 10; write MTIMECMP_LO = 0xFFFFFFFF -> t_irq_out = 0 two cycles later.
6. Assert rst_n_in low mid IN_SERVICE with MSIP = 1 -> all outputs return to reset values asynchronously and claim_id_out = 0x1F.
